btn_evt: RTL and testbench

//  Consumer of the debouncer's one-cycle press pulse. Turns press pulses and
//  the held button level into one-cycle gesture events: single click, double

---
 rtl/btn_evt.sv | 81 ++++++++
 tb/tb_btn_evt.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_evt.sv
// btn_evt: turns debounced press pulses and held level into one-cycle single/double/long-press events
module btn_evt #(
  parameter int CW = 26,
  parameter logic [CW-1:0] DBL_WIN = 26'd12_500_000,
  parameter logic [CW-1:0] LONG_T = 26'd50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_press,
  input  logic i_held,
  output logic o_single,
  output logic o_double,
  output logic o_long,
  output logic o_busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRESS1 = 2'd1;
  localparam logic [1:0] WAIT2 = 2'd2;
  localparam logic [1:0] LOCK = 2'd3;
  localparam logic [CW-1:0] DW1 = DBL_WIN - 1'b1;
  localparam logic [CW-1:0] LT1 = LONG_T - 1'b1;
  logic [1:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic single_n, double_n, long_n;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    single_n = 1'b0;
    double_n = 1'b0;
    long_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = i_press ? PRESS1 : IDLE;
        cnt_n = i_press ? '0 : cnt;
      end
      PRESS1: begin
        cnt_n = cnt_inc;
        if (i_press) begin
          double_n = cnt <= DW1;
          state_n = (cnt <= DW1) ? LOCK : PRESS1;
          cnt_n = (cnt <= DW1) ? cnt_inc : '0;
        end else if (!i_held) begin
          single_n = cnt >= DW1;
          state_n = (cnt >= DW1) ? IDLE : WAIT2;
        end else if (cnt == LT1) begin
          long_n = 1'b1;
          state_n = LOCK;
        end
      end
      WAIT2: begin
        cnt_n = cnt_inc;
        if (i_press) begin
          double_n = 1'b1;
          state_n = LOCK;
        end else if (cnt == DW1) begin
          single_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = (!i_held && !i_press) ? IDLE : LOCK;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      o_single <= 1'b0;
      o_double <= 1'b0;
      o_long <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_single <= single_n;
      o_double <= double_n;
      o_long <= long_n;
      o_busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_btn_evt.sv
// tb_btn_evt: randomized and directed self-checking bench for btn_evt against an elapsed-time gesture model
module tb_btn_evt;
  localparam int DBL_WIN = 10;
  localparam int LONG_T = 40;
  logic i_clk = 1'b0, i_rst = 1'b1, i_press = 1'b0, i_held = 1'b0;
  logic o_single, o_double, o_long, o_busy;
  typedef enum int {NONE, HOLDING, RELEASED, ABSORB} mode_t;
  mode_t m = NONE;
  int now = 0, t0 = 0, n_vec = 0, n_bad = 0;
  logic [3:0] exp_o = 4'b0;
  btn_evt #(.CW(26), .DBL_WIN(26'd10), .LONG_T(26'd40)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_press(i_press),
    .i_held(i_held),
    .o_single(o_single),
    .o_double(o_double),
    .o_long(o_long),
    .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic cyc(input bit r, input bit p, input bit h);
    int e;
    bit s = 1'b0, d = 1'b0, l = 1'b0;
    i_rst = r;
    i_press = p;
    i_held = h;
    @(posedge i_clk);
    now++;
    e = now - t0 - 1;
    if (r) m = NONE;
    else if (m == NONE) begin
      if (p) begin
        m = HOLDING;
        t0 = now;
      end
    end else if (m == ABSORB) begin
      if (!h && !p) m = NONE;
    end else if (p) begin
      if (e < DBL_WIN) begin
        d = 1'b1;
        m = ABSORB;
      end else t0 = now;
    end else if (m == HOLDING) begin
      if (!h) begin
        if (e >= DBL_WIN - 1) begin
          s = 1'b1;
          m = NONE;
        end else m = RELEASED;
      end else if (e == LONG_T - 1) begin
        l = 1'b1;
        m = ABSORB;
      end
    end else if (e == DBL_WIN - 1) begin
      s = 1'b1;
      m = NONE;
    end
    exp_o = {s, d, l, m != NONE};
    #1;
  endtask
  task automatic test_reset();
    bit [2:0] rp [4] = '{3'b100, 3'b100, 3'b111, 3'b001};
    for (int i = 0; i < 4; i++) begin
      cyc(rp[i][2], rp[i][1], rp[i][0]);
      n_vec++;
      if ({o_single, o_double, o_long, o_busy} !== 4'b0000 || exp_o !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset step=%0d got=%b model=%b required=0000", i, {o_single, o_double, o_long, o_busy}, exp_o);
      end
    end
  endtask
  task automatic test_single();
    int hit = -1, cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, i == 0, i <= 3);
      n_vec++;
      if ({o_single, o_double, o_long, o_busy} !== exp_o) begin
        n_bad++;
        $display("FAIL single cyc=%0d got=%b exp=%b", i, {o_single, o_double, o_long, o_busy}, exp_o);
      end
      if (o_single) begin
        cnt++;
        hit = i;
      end
      if (i == 10) begin
        n_vec++;
        if (o_busy !== 1'b0) begin
          n_bad++;
          $display("FAIL single_busy cyc=10 got=%b exp=0", o_busy);
        end
      end
    end
    n_vec++;
    if (cnt != 1 || hit != 10) begin
      n_bad++;
      $display("FAIL single_timing count=%0d at=%0d exp count=1 at=10", cnt, hit);
    end
  endtask
  task automatic test_double();
    int hit = -1, nd = 0, ns = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, i == 0 || i == 6, i <= 2 || (i >= 6 && i <= 8));
      n_vec++;
      if ({o_single, o_double, o_long, o_busy} !== exp_o) begin
        n_bad++;
        $display("FAIL double cyc=%0d got=%b exp=%b", i, {o_single, o_double, o_long, o_busy}, exp_o);
      end
      if (o_double) begin
        nd++;
        hit = i;
      end
      ns += o_single;
    end
    n_vec++;
    if (nd != 1 || hit != 6 || ns != 0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL double_timing doubles=%0d at=%0d singles=%0d busy=%b exp 1 at 6, 0 singles, busy 0", nd, hit, ns, o_busy);
    end
  endtask
  task automatic test_long();
    int hit = -1, nl = 0, ns = 0;
    for (int i = 0; i < 70; i++) begin
      cyc(1'b0, i == 0, i <= 60);
      n_vec++;
      if ({o_single, o_double, o_long, o_busy} !== exp_o) begin
        n_bad++;
        $display("FAIL long cyc=%0d got=%b exp=%b", i, {o_single, o_double, o_long, o_busy}, exp_o);
      end
      if (o_long) begin
        nl++;
        hit = i;
      end
      ns += o_single;
    end
    n_vec++;
    if (nl != 1 || hit != 40 || ns != 0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL long_timing longs=%0d at=%0d singles=%0d busy=%b exp 1 at 40, 0 singles, busy 0", nl, hit, ns, o_busy);
    end
  endtask
  task automatic test_window_edge();
    int first = -1, ns = 0, nd = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, i == 0 || i == 11, i <= 3 || i == 11 || i == 12);
      n_vec++;
      if ({o_single, o_double, o_long, o_busy} !== exp_o) begin
        n_bad++;
        $display("FAIL window cyc=%0d got=%b exp=%b", i, {o_single, o_double, o_long, o_busy}, exp_o);
      end
      if (o_single && first < 0) first = i;
      ns += o_single;
      nd += o_double;
      if (i == 11) begin
        n_vec++;
        if (o_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL window_restart cyc=11 busy got=%b exp=1", o_busy);
        end
      end
    end
    n_vec++;
    if (first != 10 || ns != 2 || nd != 0) begin
      n_bad++;
      $display("FAIL window_timing first_single=%0d singles=%0d doubles=%0d exp 10, 2, 0", first, ns, nd);
    end
  endtask
  task automatic test_reset_mid();
    int ev = 0, busy = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(i == 5, i == 0, i <= 12);
      n_vec++;
      if ({o_single, o_double, o_long, o_busy} !== exp_o) begin
        n_bad++;
        $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i, {o_single, o_double, o_long, o_busy}, exp_o);
      end
      if (i >= 5) begin
        ev += o_single + o_double + o_long;
        busy += o_busy;
      end
    end
    n_vec++;
    if (ev != 0 || busy != 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet events=%0d busy_cycles=%0d exp 0, 0", ev, busy);
    end
  endtask
  task automatic test_random();
    bit h = 1'b0, p, r;
    int run = 3, ev = 0;
    for (int i = 0; i < 4000; i++) begin
      p = 1'b0;
      if (run == 0) begin
        h = !h;
        run = h ? $urandom_range(1, 55) : $urandom_range(1, 14);
        p = h;
      end else run--;
      if ($urandom_range(0, 40) == 0) p = 1'b1;
      r = $urandom_range(0, 499) == 0;
      cyc(r, p, h);
      n_vec++;
      if ({o_single, o_double, o_long, o_busy} !== exp_o) begin
        n_bad++;
        $display("FAIL random cyc=%0d rst=%b press=%b held=%b got=%b exp=%b", i, r, p, h, {o_single, o_double, o_long, o_busy}, exp_o);
      end
      ev += o_single + o_double + o_long;
      n_vec++;
      if (int'(o_single) + int'(o_double) + int'(o_long) > 1) begin
        n_bad++;
        $display("FAIL onehot cyc=%0d got=%b exp at most one event", i, {o_single, o_double, o_long});
      end
    end
    n_vec++;
    if (ev == 0) begin
      n_bad++;
      $display("FAIL random_activity events=%0d exp >0", ev);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_double();
    test_long();
    test_window_edge();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
